uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, interrupt-cause bit indices and timeout FSM encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned OVF_W   = 8;
  localparam int unsigned ITR_W   = 3;

  // itr_status bit positions: {ovf, timeout, thres}
  localparam int unsigned ITR_THRES   = 0;
  localparam int unsigned ITR_TIMEOUT = 1;
  localparam int unsigned ITR_OVF     = 2;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_ARMED = 2'd1,
    TO_FIRED = 2'd2
  } to_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head byte and fill count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(depth):0]   cnt,
  output logic [$clog2(depth):0]   cnt_nxt_c,
  output logic                     wr_acc_c,
  output logic                     rd_acc_c
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [depth];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_nxt_c;
  logic [AW-1:0]     rd_ptr_nxt_c;
  logic [DATA_W-1:0] head_nxt_c;
  logic              full_c;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    full_c       = (cnt == CW'(depth));
    rd_acc_c     = rd_en & rd_valid;
    wr_acc_c     = wr_en & (~full_c | rd_acc_c);
    cnt_nxt_c    = cnt + CW'(wr_acc_c) - CW'(rd_acc_c);
    wr_ptr_nxt_c = wr_ptr_q + AW'(wr_acc_c);
    rd_ptr_nxt_c = rd_ptr_q + AW'(rd_acc_c);
    // Next head bypasses the array when it is the slot being written this cycle.
    if (wr_acc_c && (rd_ptr_nxt_c == wr_ptr_q)) begin
      head_nxt_c = wr_data;
    end else begin
      head_nxt_c = mem_q[rd_ptr_nxt_c];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt_c;
      rd_ptr_q <= rd_ptr_nxt_c;
      cnt      <= cnt_nxt_c;
      rd_valid <= (cnt_nxt_c != '0);
      rd_data  <= head_nxt_c;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, overflow counting and sticky interrupt causes.
// Define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout FSM; otherwise the timeout cause is tied low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned fifo_depth       = 16,
  parameter real         simulation_delay = 1.0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             rx_byte_data,
  input  logic                          rx_byte_valid,
  input  logic                          rx_idle,
  output logic [DATA_W-1:0]             m_axis_data,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  input  logic [$clog2(fifo_depth):0]   rx_thres,
  input  logic [TIMER_W-1:0]            timeout_th,
  output logic [$clog2(fifo_depth):0]   fifo_cnt,
  output logic [OVF_W-1:0]              ovf_cnt,
  output logic                          itr_req,
  output logic [ITR_W-1:0]              itr_status,
  input  logic [ITR_W-1:0]              itr_clr
);

  localparam int unsigned CW = $clog2(fifo_depth) + 1;

  // simulation_delay only shapes behavioural models; these registers update with zero delay.
  if (simulation_delay < 0.0) begin : g_neg_sim_delay
  end

  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] cnt_nxt_c;
  logic          drop_c;
  logic          thres_hit_c;
  logic          to_fire_c;
  logic [ITR_W-1:0] status_set_c;
  logic [ITR_W-1:0] status_nxt_c;
  logic [ITR_W-1:0] status_d_q;
  logic [OVF_W-1:0] ovf_nxt_c;

  uart_rx_fifo #(
    .depth(fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rx_byte_valid),
    .wr_data   (rx_byte_data),
    .rd_en     (m_axis_ready),
    .rd_data   (m_axis_data),
    .rd_valid  (m_axis_valid),
    .cnt       (fifo_cnt),
    .cnt_nxt_c (cnt_nxt_c),
    .wr_acc_c  (push_c),
    .rd_acc_c  (pop_c)
  );

  assign drop_c      = rx_byte_valid & ~push_c;
  assign thres_hit_c = (rx_thres != '0) && (fifo_cnt < rx_thres) && (cnt_nxt_c >= rx_thres);

`ifdef UART_RX_CTRL_TIMEOUT_EN
  to_state_e          state_q;
  to_state_e          state_nxt;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TO_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
    end
  end

  // Timer counts quiet idle cycles while bytes wait; any FIFO traffic restarts it.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    case (state_q)
      TO_IDLE: begin
        timer_nxt = '0;
        if (cnt_nxt_c != '0) state_nxt = TO_ARMED;
      end
      TO_ARMED: begin
        if (cnt_nxt_c == '0) begin
          state_nxt = TO_IDLE;
          timer_nxt = '0;
        end else if (push_c || pop_c) begin
          timer_nxt = '0;
        end else if (rx_idle) begin
          if ((timeout_th != '0) && (timer_q == timeout_th - TIMER_W'(1))) begin
            state_nxt = TO_FIRED;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer_q + TIMER_W'(1);
          end
        end
      end
      TO_FIRED: begin
        timer_nxt = '0;
        if (cnt_nxt_c == '0) state_nxt = TO_IDLE;
        else if (push_c)     state_nxt = TO_ARMED;
      end
      default: begin
        state_nxt = TO_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    to_fire_c = (state_q == TO_ARMED) && (state_nxt == TO_FIRED);
  end
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^{rx_idle, timeout_th};
  assign to_fire_c        = 1'b0;
`endif

  // New causes win over a same-cycle write-1-to-clear.
  always_comb begin
    status_set_c              = '0;
    status_set_c[ITR_THRES]   = thres_hit_c;
    status_set_c[ITR_TIMEOUT] = to_fire_c;
    status_set_c[ITR_OVF]     = drop_c;
    status_nxt_c              = (itr_status & ~itr_clr) | status_set_c;
    ovf_nxt_c                 = ovf_cnt;
    if (drop_c && (ovf_cnt != '1)) ovf_nxt_c = ovf_cnt + OVF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itr_status <= '0;
      status_d_q <= '0;
      itr_req    <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      itr_status <= status_nxt_c;
      status_d_q <= itr_status;
      itr_req    <= |(itr_status & ~status_d_q);
      ovf_cnt    <= ovf_nxt_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model plus directed scenarios.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam bit EXP_TO = 1'b1;
`else
  localparam bit EXP_TO = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_byte_data;
  logic          rx_byte_valid;
  logic          rx_idle;
  logic [7:0]    m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [CW-1:0] rx_thres;
  logic [15:0]   timeout_th;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    ovf_cnt;
  logic          itr_req;
  logic [2:0]    itr_status;
  logic [2:0]    itr_clr;

  uart_rx_ctrl #(.fifo_depth(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_byte_data  (rx_byte_data),
    .rx_byte_valid (rx_byte_valid),
    .rx_idle       (rx_idle),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .rx_thres      (rx_thres),
    .timeout_th    (timeout_th),
    .fifo_cnt      (fifo_cnt),
    .ovf_cnt       (ovf_cnt),
    .itr_req       (itr_req),
    .itr_status    (itr_status),
    .itr_clr       (itr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus sticky cause bits.
  logic [7:0] mq[$];
  int         m_ovf;
  logic [2:0] m_status;
  bit         m_req;
  bit         m_rise;
  int         m_quiet;
  bit         m_fired;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_status = '0; m_req = 0; m_rise = 0; m_quiet = 0; m_fired = 0;
    end else begin : model_step
      int prev;
      bit pop;
      bit push;
      logic [2:0] set;
      logic [2:0] old;
      prev = mq.size();
      pop  = (prev > 0) && m_axis_ready;
      push = 0;
      set  = '0;
      if (pop) void'(mq.pop_front());
      if (rx_byte_valid) begin
        if (prev < DEPTH || pop) begin
          mq.push_back(rx_byte_data);
          push = 1;
        end else begin
          if (m_ovf < 255) m_ovf++;
          set[2] = 1'b1;
        end
      end
      if (rx_thres != 0 && prev < int'(rx_thres) && mq.size() >= int'(rx_thres)) set[0] = 1'b1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      if (mq.size() == 0 || prev == 0 || push) begin
        m_quiet = 0; m_fired = 0;
      end else if (pop) begin
        m_quiet = 0;
      end else if (!m_fired && rx_idle) begin
        m_quiet++;
        if (timeout_th != 0 && m_quiet == int'(timeout_th)) begin
          set[1] = 1'b1; m_fired = 1; m_quiet = 0;
        end
      end
`endif
      old      = m_status;
      m_req    = m_rise;
      m_status = (m_status & ~itr_clr) | set;
      m_rise   = |(m_status & ~old);
    end
  end

  always @(negedge clk) begin
    chk("m_axis_valid", 32'(m_axis_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("m_axis_data", 32'(m_axis_data), 32'(mq[0]));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("itr_status", 32'(itr_status), 32'(m_status));
    chk("itr_req", 32'(itr_req), 32'(m_req));
    if (itr_req) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_byte_data  = d;
    rx_byte_valid = 1'b1;
    tick(1);
    rx_byte_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_byte_data = '0; rx_byte_valid = 1'b0; rx_idle = 1'b1;
    m_axis_ready = 1'b0; rx_thres = '0; timeout_th = '0; itr_clr = '0;
    tick(3);
    chk("rst_valid", 32'(m_axis_valid), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_status", 32'(itr_status), 32'd0);
    chk("rst_req", 32'(itr_req), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Pass-through with consumer always ready.
    m_axis_ready = 1'b1;
    push_byte(8'h55);
    chk("a_valid0", 32'(m_axis_valid), 32'd1);
    chk("a_data0", 32'(m_axis_data), 32'h55);
    push_byte(8'hAA);
    chk("a_valid1", 32'(m_axis_valid), 32'd1);
    chk("a_data1", 32'(m_axis_data), 32'hAA);
    tick(1);
    chk("a_empty", 32'(m_axis_valid), 32'd0);
    m_axis_ready = 1'b0;

    // Overflow: 17 bytes into a 16-deep FIFO.
    pulses = 0;
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
    chk("b_cnt", 32'(fifo_cnt), 32'd16);
    chk("b_ovf", 32'(ovf_cnt), 32'd1);
    chk("b_status", 32'(itr_status), 32'b100);
    chk("b_head", 32'(m_axis_data), 32'h10);
    tick(3);
    chk("b_pulses", 32'(pulses), 32'd1);
    itr_clr = 3'b100;
    push_byte(8'hEE);
    itr_clr = 3'b000;
    chk("b_set_prio", 32'(itr_status), 32'b100);
    chk("b_ovf2", 32'(ovf_cnt), 32'd2);
    m_axis_ready = 1'b1;
    push_byte(8'h77);
    m_axis_ready = 1'b0;
    chk("b_fullpp_cnt", 32'(fifo_cnt), 32'd16);
    chk("b_fullpp_ovf", 32'(ovf_cnt), 32'd2);
    chk("b_fullpp_head", 32'(m_axis_data), 32'h11);
    itr_clr = 3'b111;
    tick(1);
    itr_clr = 3'b000;
    chk("b_cleared", 32'(itr_status), 32'd0);
    m_axis_ready = 1'b1;
    tick(20);
    m_axis_ready = 1'b0;
    chk("b_drained", 32'(fifo_cnt), 32'd0);

    // Fill-level threshold.
    rx_thres = 5'd4;
    pulses = 0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'hA0 + i));
    chk("c_below", 32'(itr_status), 32'd0);
    push_byte(8'hA3);
    chk("c_status", 32'(itr_status), 32'b001);
    chk("c_req_lag", 32'(itr_req), 32'd0);
    tick(1);
    chk("c_req", 32'(itr_req), 32'd1);
    push_byte(8'hA4);
    tick(3);
    chk("c_pulses", 32'(pulses), 32'd1);
    chk("c_cnt", 32'(fifo_cnt), 32'd5);

    // Asynchronous reset with bytes queued.
    rst_n = 1'b0;
    #1;
    chk("d_valid", 32'(m_axis_valid), 32'd0);
    chk("d_cnt", 32'(fifo_cnt), 32'd0);
    chk("d_status", 32'(itr_status), 32'd0);
    chk("d_ovf", 32'(ovf_cnt), 32'd0);
    tick(2);
    rst_n = 1'b1;
    rx_thres = '0;
    tick(1);

    // Idle timeout, restarted by a second byte 50 cycles in.
    timeout_th = 16'd100;
    push_byte(8'h31);
    tick(49);
    push_byte(8'h32);
    tick(99);
    chk("e_not_yet", 32'(itr_status[1]), 32'd0);
    tick(1);
    chk("e_fired", 32'(itr_status[1]), 32'(EXP_TO));
    tick(2);
    timeout_th = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
